// File: rtl/cache_refill_ctrl_if.sv
// Refill-controller bundle: miss request, PLRU hit feed, memory read burst,
// data-RAM write stream and tag-RAM fill pulse.
// Latency: n/a (wires only). Backpressure: memory side via mem_ack, miss side via miss_ready.
// Modports: slave = the refill controller, master = the cache/memory side driving it.
interface cache_refill_ctrl_if #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int BEATS       = 4,
  parameter int DATA_WIDTH  = 32
) ();
  localparam int BEAT_W = $clog2(BEATS);

  // miss request
  logic                   miss_req;
  logic [ADDR_WIDTH-1:0]  miss_addr;
  logic                   miss_ready;
  // lookup hit feed for replacement state
  logic                   access_valid;
  logic [INDEX_WIDTH-1:0] access_index;
  logic [3:0]             hit_en;
  // main-memory burst read
  logic                   mem_req;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [BEAT_W-1:0]      mem_beat;
  logic                   mem_ack;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  // data-RAM write stream
  logic                   refill_we;
  logic [1:0]             refill_way;
  logic [INDEX_WIDTH-1:0] refill_index;
  logic [BEAT_W-1:0]      refill_beat;
  logic [DATA_WIDTH-1:0]  refill_wdata;
  // tag-RAM fill
  logic                   read_main_memory_en;
  logic [ADDR_WIDTH-1:0]  addr_to_main_memory;
  logic [2:0]             replaced_way;
  logic                   refill_done;

  modport slave (
    input  miss_req, miss_addr, access_valid, access_index, hit_en, mem_ack, mem_rdata,
    output miss_ready, mem_req, mem_addr, mem_beat, refill_we, refill_way, refill_index,
           refill_beat, refill_wdata, read_main_memory_en, addr_to_main_memory,
           replaced_way, refill_done
  );

  modport master (
    output miss_req, miss_addr, access_valid, access_index, hit_en, mem_ack, mem_rdata,
    input  miss_ready, mem_req, mem_addr, mem_beat, refill_we, refill_way, refill_index,
           refill_beat, refill_wdata, read_main_memory_en, addr_to_main_memory,
           replaced_way, refill_done
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Miss handler for a 4-way set-associative cache: victim select, burst refill, tag fill pulse.
// Latency: acceptance + one cycle per acked beat + one COMMIT cycle (6 cycles with no stalls).
// Backpressure: holds FETCH while mem_ack is low; miss_ready only high in IDLE.
// Ports: clk, rst (async, active-high); bus (slave modport) carries miss request,
//        PLRU hit feed, memory burst, data-RAM write stream and tag-RAM fill outputs.
module cache_refill_ctrl #(
  parameter int ADDR_WIDTH  = 8,
  parameter int INDEX_WIDTH = 4,
  parameter int WAY_NUM     = 4,
  parameter int BEATS       = 4,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst,
  cache_refill_ctrl_if.slave  bus
);
  localparam int LINE_NUM = 1 << INDEX_WIDTH;
  localparam int BEAT_W   = $clog2(BEATS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_COMMIT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [1:0]             r_victim;
  logic [BEAT_W-1:0]      r_beat;
  logic [ADDR_WIDTH-1:0]  r_fill_addr;
  logic [1:0]             r_fill_way;
  // Per-set mirrors; plru bit0 = b0 (pair select), bit1 = b1 (ways 0/1), bit2 = b2 (ways 2/3).
  logic [WAY_NUM-1:0]     r_valid [LINE_NUM];
  logic [2:0]             r_plru  [LINE_NUM];

  logic                   w_accept;
  logic                   w_fetch_ack;
  logic                   w_commit;
  logic [INDEX_WIDTH-1:0] w_miss_set;
  logic [INDEX_WIDTH-1:0] w_commit_set;
  logic [1:0]             w_victim;
  logic                   w_hit_any;
  logic [1:0]             w_hit_way;

  function automatic logic [1:0] plru_victim(input logic [2:0] p);
    logic [1:0] v;
    if (!p[0]) v = p[1] ? 2'd1 : 2'd0;
    else       v = p[2] ? 2'd3 : 2'd2;
    return v;
  endfunction

  // Point the tree away from the touched way.
  function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] w);
    logic [2:0] n;
    n = p;
    case (w)
      2'd0:    begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1:    begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2:    begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

  assign w_miss_set   = bus.miss_addr[ADDR_WIDTH-1 -: INDEX_WIDTH];
  assign w_commit_set = r_addr[ADDR_WIDTH-1 -: INDEX_WIDTH];

  // Lowest-numbered invalid way wins; PLRU only decides when the set is full.
  always_comb begin
    w_victim = plru_victim(r_plru[w_miss_set]);
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (!r_valid[w_miss_set][w]) w_victim = 2'(w);
    end
  end

  // Lowest set bit of the hit vector is the way touched.
  always_comb begin
    w_hit_way = 2'd0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      if (bus.hit_en[w]) w_hit_way = 2'(w);
    end
  end
  assign w_hit_any = bus.access_valid && (|bus.hit_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fetch_ack = 1'b0;
    w_commit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.miss_req) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (bus.mem_ack) begin
          w_fetch_ack = 1'b1;
          if (r_beat == BEAT_W'(BEATS - 1)) w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        w_commit    = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_victim    <= '0;
      r_beat      <= '0;
      r_fill_addr <= '0;
      r_fill_way  <= '0;
    end else begin
      if (w_accept) begin
        r_addr   <= bus.miss_addr;
        r_victim <= w_victim;
        r_beat   <= '0;
      end
      if (w_fetch_ack) r_beat <= r_beat + 1'b1;
      if (w_commit) begin
        r_fill_addr <= r_addr;
        r_fill_way  <= r_victim;
      end
    end
  end

  // A hit to the set being committed is dropped so the refill touch stands alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < LINE_NUM; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (w_hit_any && !(w_commit && (bus.access_index == w_commit_set)))
        r_plru[bus.access_index] <= plru_touch(r_plru[bus.access_index], w_hit_way);
      if (w_commit) begin
        r_valid[w_commit_set][r_victim] <= 1'b1;
        r_plru[w_commit_set]            <= plru_touch(r_plru[w_commit_set], r_victim);
      end
    end
  end

  assign bus.miss_ready   = (r_state == S_IDLE);
  assign bus.mem_req      = (r_state == S_FETCH);
  assign bus.mem_addr     = r_addr;
  assign bus.mem_beat     = r_beat;
  assign bus.refill_we    = w_fetch_ack;
  assign bus.refill_way   = r_victim;
  assign bus.refill_index = w_commit_set;
  assign bus.refill_beat  = r_beat;
  assign bus.refill_wdata = w_fetch_ack ? bus.mem_rdata : '0;

  // Fill outputs show the current line during COMMIT and keep it until the next one.
  assign bus.read_main_memory_en = w_commit;
  assign bus.refill_done         = w_commit;
  assign bus.addr_to_main_memory = w_commit ? r_addr : r_fill_addr;
  assign bus.replaced_way        = {1'b0, (w_commit ? r_victim : r_fill_way)};
endmodule
